viterbi_decoder: RTL

//  Hard-decision Viterbi decoder for the K=3, rate-1/2 (7,5) convolutional code produced by the encoder stage.

---
 rtl/viterbi_decoder_if.sv | 21 ++
 rtl/viterbi_decoder.sv | 114 +++++++++++
 2 files changed

// File: rtl/viterbi_decoder_if.sv
// Serial code-bit input and decoded-bit output bundle of the viterbi_decoder.
// The master drives code bits; the slave (the decoder) returns decoded bits and the best metric.
interface viterbi_decoder_if #(
  parameter int PM_W = 6
);
  logic            in_valid;
  logic            serial_in;
  logic            decode_valid;
  logic            decode_sig;
  logic [PM_W-1:0] best_metric;

  modport master (
    output in_valid, serial_in,
    input  decode_valid, decode_sig, best_metric
  );

  modport slave (
    input  in_valid, serial_in,
    output decode_valid, decode_sig, best_metric
  );
endinterface

// File: rtl/viterbi_decoder.sv
// Hard-decision Viterbi decoder for the K=3, rate-1/2 (7,5) code.
// Pairs serial code bits into symbols, runs 4-state ACS with register-exchange survivors.
module viterbi_decoder #(
  parameter int TB_DEPTH = 16,
  parameter int PM_W     = 6,
  parameter int PM_INIT  = 4
) (
  input  logic             clk20M_sig,
  input  logic             reset_sig,
  viterbi_decoder_if.slave bus
);
  localparam int            CW     = $clog2(TB_DEPTH + 1);
  localparam logic [PM_W:0] PM_SAT = {1'b0, {PM_W{1'b1}}};

  logic                phase;
  logic                g0_hold;
  logic [PM_W-1:0]     metric [4];
  logic [TB_DEPTH-1:0] path   [4];
  logic [CW-1:0]       sym_cnt;

  logic                acs_fire;
  logic [1:0]          rx;
  logic [PM_W:0]       new_metric [4];
  logic [TB_DEPTH-1:0] new_path   [4];
  logic [PM_W:0]       min_metric;
  logic [1:0]          best;

  assign acs_fire = bus.in_valid & phase;
  assign rx       = {g0_hold, bus.serial_in};

  function automatic logic [1:0] hamming(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] d;
    d = a ^ b;
    return {1'b0, d[1]} + {1'b0, d[0]};
  endfunction

  // One extra bit holds the raw sum; clamping keeps stored metrics from wrapping.
  function automatic logic [PM_W:0] sat_add(input logic [PM_W-1:0] m, input logic [1:0] bm);
    logic [PM_W:0] s;
    s = {1'b0, m} + {{(PM_W-1){1'b0}}, bm};
    return (s > PM_SAT) ? PM_SAT : s;
  endfunction

  // Next state {x,y} is reached from {y,0} (taken on ties) or {y,1} with input bit x.
  for (genvar i = 0; i < 4; i++) begin : g_acs
    localparam logic [1:0] NS = 2'(i);
    localparam logic       X  = NS[1];
    localparam logic       Y  = NS[0];
    localparam logic [1:0] P0 = {Y, 1'b0};
    localparam logic [1:0] P1 = {Y, 1'b1};
    localparam logic [1:0] E0 = {X ^ Y, X};
    localparam logic [1:0] E1 = {~(X ^ Y), ~X};

    logic [PM_W:0] cand0;
    logic [PM_W:0] cand1;
    logic          take1;

    assign cand0         = sat_add(metric[P0], hamming(rx, E0));
    assign cand1         = sat_add(metric[P1], hamming(rx, E1));
    assign take1         = cand1 < cand0;
    assign new_metric[i] = take1 ? cand1 : cand0;
    assign new_path[i]   = {take1 ? path[P1][TB_DEPTH-2:0] : path[P0][TB_DEPTH-2:0], X};
  end

  always_comb begin
    // NOTE: defaults before the search loop keep this purely combinational (no latch).
    best       = 2'd0;
    min_metric = new_metric[0];
    for (int i = 1; i < 4; i++) begin
      if (new_metric[i] < min_metric) begin
        min_metric = new_metric[i];
        best       = 2'(i);
      end
    end
  end

  always_ff @(posedge clk20M_sig or posedge reset_sig) begin
    if (reset_sig) begin
      phase            <= 1'b0;
      g0_hold          <= 1'b0;
      sym_cnt          <= '0;
      bus.decode_valid <= 1'b0;
      bus.decode_sig   <= 1'b0;
      bus.best_metric  <= '0;
      // NOTE: metric and survivor arrays are tiny flop banks whose reset values define the
      // starting trellis state, so they are cleared here rather than left uninitialised.
      metric[0] <= '0;
      path[0]   <= '0;
      for (int i = 1; i < 4; i++) begin
        metric[i] <= PM_W'(PM_INIT);
        path[i]   <= '0;
      end
    end else begin
      // NOTE: all state updates are non-blocking so every ACS reads the pre-edge metrics.
      bus.decode_valid <= 1'b0;
      if (acs_fire) begin
        phase <= 1'b0;
        for (int i = 0; i < 4; i++) begin
          metric[i] <= PM_W'(new_metric[i] - min_metric);
          path[i]   <= new_path[i];
        end
        if (sym_cnt < CW'(TB_DEPTH)) sym_cnt <= sym_cnt + CW'(1);
        bus.best_metric <= min_metric[PM_W-1:0];
        if (sym_cnt >= CW'(TB_DEPTH - 1)) begin
          bus.decode_valid <= 1'b1;
          bus.decode_sig   <= new_path[best][TB_DEPTH-1];
        end
      end else if (bus.in_valid) begin
        g0_hold <= bus.serial_in;
        phase   <= 1'b1;
      end
    end
  end
endmodule
